// File: rtl/pipe_hazard_scoreboard.sv
// Hazard scoreboard for the in-order 5-stage pipeline: per-register write countdowns plus a
// writeback-port reservation shifter, producing the ID stall and its RAW/WAW/WB cause flags.
module pipe_hazard_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_W    = 5,
    parameter int MAX_LAT  = 7,
    parameter int LAT_W    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic             flush,
    input  logic             issue_wb_en,
    input  logic [REG_W-1:0] issue_dest,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic [LAT_W-1:0] issue_wb_ext,
    input  logic [REG_W-1:0] src_rs,
    input  logic [REG_W-1:0] src_rt,
    input  logic             rs_used,
    input  logic             rt_used,
    output logic             stall,
    output logic             stall_raw,
    output logic             stall_waw,
    output logic             stall_wb,
    output logic             idle
);

    localparam int RES_W = MAX_LAT + 1;
    localparam logic [LAT_W:0] MAX_LAT_V = (LAT_W + 1)'(MAX_LAT);

    logic [LAT_W-1:0] r_cnt [NUM_REGS];
    logic [RES_W-1:0] r_res;
    logic             r_idle;

    logic [LAT_W-1:0] w_lat;
    logic [LAT_W-1:0] w_ext;
    logic             w_wr;
    logic             w_issue;
    logic [LAT_W-1:0] w_cnt_next [NUM_REGS];
    logic [RES_W-1:0] w_res_set;
    logic [RES_W-1:0] w_res_next;
    logic             w_any_cnt;

    // Out-of-range latencies saturate rather than alias to a short value.
    assign w_lat = ({1'b0, issue_lat} > MAX_LAT_V) ? MAX_LAT_V[LAT_W-1:0] : issue_lat;
    assign w_ext = ({1'b0, issue_wb_ext} > MAX_LAT_V) ? MAX_LAT_V[LAT_W-1:0] : issue_wb_ext;

    // r0 writes are invisible to every hazard check and to the tables.
    assign w_wr = issue_wb_en && (issue_dest != '0);

    assign stall_raw = (rs_used && (r_cnt[src_rs] != '0)) ||
                       (rt_used && (r_cnt[src_rt] != '0));
    assign stall_waw = issue_valid && w_wr && (r_cnt[issue_dest] > w_lat);
    assign stall_wb  = issue_valid && w_wr && r_res[w_ext];
    assign stall     = stall_raw || stall_waw || stall_wb;

    assign w_issue = issue_valid && !flush && !stall;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            w_cnt_next[r] = '0;
            if (r != 0) begin
                if (w_issue && w_wr && (issue_dest == REG_W'(r))) begin
                    w_cnt_next[r] = w_lat;
                end else if (r_cnt[r] != '0) begin
                    w_cnt_next[r] = r_cnt[r] - LAT_W'(1);
                end
            end
        end
    end

    always_comb begin
        w_res_set = '0;
        if (w_issue && w_wr) begin
            w_res_set[w_ext] = 1'b1;
        end
        w_res_next = (r_res | w_res_set) >> 1;
    end

    always_comb begin
        w_any_cnt = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
            w_any_cnt = w_any_cnt || (w_cnt_next[r] != '0);
        end
    end

    // NOTE: the counter table is real pipeline state, not a data memory, so it is cleared
    // by reset; a mid-operation reset must drop every tracked write at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                r_cnt[r] <= '0;
            end
            r_res  <= '0;
            r_idle <= 1'b1;
        end else begin
            r_cnt  <= w_cnt_next;
            r_res  <= w_res_next;
            r_idle <= !w_any_cnt && (w_res_next == '0);
        end
    end

    assign idle = r_idle;

    a_r0_zero : assert property (@(posedge clk) disable iff (rst) r_cnt[0] == '0);
    a_idle_quiet : assert property (@(posedge clk) disable iff (rst)
        idle |-> !stall_raw && !stall_waw && !stall_wb);

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Directed bench for pipe_hazard_scoreboard: a ready-time/writeback-cycle model checked every
// cycle, plus hand-computed expectations along the directed scenarios.
module tb_pipe_hazard_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int REG_W    = 5;
    localparam int MAX_LAT  = 7;
    localparam int LAT_W    = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid, flush, issue_wb_en;
    logic [REG_W-1:0] issue_dest, src_rs, src_rt;
    logic [LAT_W-1:0] issue_lat, issue_wb_ext;
    logic             rs_used, rt_used;
    logic             stall, stall_raw, stall_waw, stall_wb, idle;

    always #5 clk = ~clk;

    pipe_hazard_scoreboard #(
        .NUM_REGS(NUM_REGS), .REG_W(REG_W), .MAX_LAT(MAX_LAT), .LAT_W(LAT_W)
    ) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .flush(flush), .issue_wb_en(issue_wb_en),
        .issue_dest(issue_dest), .issue_lat(issue_lat), .issue_wb_ext(issue_wb_ext),
        .src_rs(src_rs), .src_rt(src_rt), .rs_used(rs_used), .rt_used(rt_used),
        .stall(stall), .stall_raw(stall_raw), .stall_waw(stall_waw), .stall_wb(stall_wb),
        .idle(idle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a register is busy until its absolute ready cycle; a writeback reservation is the
    // absolute cycle index (issue cycle + extra WB delay) that an instruction claims.
    int ready_at [NUM_REGS];
    bit busy [0:1023];
    int now = 0;

    function automatic int lat_c(input logic [LAT_W-1:0] v);
        int x = int'(v);
        return (x > MAX_LAT) ? MAX_LAT : x;
    endfunction

    function automatic bit m_wr();
        return issue_wb_en && (issue_dest != '0);
    endfunction

    function automatic bit m_raw();
        return (rs_used && (ready_at[int'(src_rs)] > now)) ||
               (rt_used && (ready_at[int'(src_rt)] > now));
    endfunction

    function automatic bit m_waw();
        return issue_valid && m_wr() && ((ready_at[int'(issue_dest)] - now) > lat_c(issue_lat));
    endfunction

    function automatic bit m_wb();
        return issue_valid && m_wr() && busy[now + lat_c(issue_wb_ext)];
    endfunction

    function automatic bit m_idle();
        bit b = 1'b1;
        foreach (ready_at[i]) if (ready_at[i] > now) b = 1'b0;
        for (int k = 0; k <= MAX_LAT; k++) if (busy[now + k]) b = 1'b0;
        return b;
    endfunction

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                foreach (ready_at[i]) ready_at[i] = 0;
                foreach (busy[i]) busy[i] = 1'b0;
            end else begin
                if (issue_valid && !flush && !(m_raw() || m_waw() || m_wb()) && m_wr()) begin
                    ready_at[int'(issue_dest)] = now + 1 + lat_c(issue_lat);
                    busy[now + lat_c(issue_wb_ext)] = 1'b1;
                end
                now++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("cmp.stall_raw", stall_raw, m_raw());
                check("cmp.stall_waw", stall_waw, m_waw());
                check("cmp.stall_wb", stall_wb, m_wb());
                check("cmp.stall", stall, m_raw() || m_waw() || m_wb());
                check("cmp.idle", idle, m_idle());
            end
        end
    end

    task automatic drive(input bit v, input bit fl, input bit we, input int dest, input int lat,
                         input int ext, input int rs, input bit rsu, input int rt, input bit rtu);
        issue_valid  = v;
        flush        = fl;
        issue_wb_en  = we;
        issue_dest   = dest[REG_W-1:0];
        issue_lat    = lat[LAT_W-1:0];
        issue_wb_ext = ext[LAT_W-1:0];
        src_rs       = rs[REG_W-1:0];
        rs_used      = rsu;
        src_rt       = rt[REG_W-1:0];
        rt_used      = rtu;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect4(input string name, input bit s, input bit r, input bit w, input bit b);
        #1;
        check({name, ".stall"}, stall, s);
        check({name, ".raw"}, stall_raw, r);
        check({name, ".waw"}, stall_waw, w);
        check({name, ".wb"}, stall_wb, b);
    endtask

    task automatic drain(input int n);
        nop();
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1;
        nop();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        nop();
        expect4("reset", 0, 0, 0, 0);
        check("reset.idle", idle, 1);
        tick();

        // Load-use: one stall cycle, and an unused rt never stalls
        drive(1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        expect4("lu.prod", 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        expect4("lu.dep0", 1, 1, 0, 0);
        check("lu.idle", idle, 0);
        tick();
        expect4("lu.dep1", 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 5, 0);
        expect4("lu.rtunused", 0, 0, 0, 0);
        tick();

        // Multiply: dependent on rt stalls exactly 3 cycles
        drain(2);
        drive(1, 0, 1, 9, 3, 3, 0, 0, 0, 0);
        expect4("mul.prod", 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 9, 1);
        for (int i = 0; i < 3; i++) begin
            expect4($sformatf("mul.dep%0d", i), 1, 1, 0, 0);
            tick();
        end
        expect4("mul.dep3", 0, 0, 0, 0);
        tick();
        drain(4);
        drive(1, 0, 1, 9, 3, 3, 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 4, 0, 0, 1, 1, 2, 1);
        expect4("mul.indep", 0, 0, 0, 0);
        tick();
        drain(5);

        // WB port conflict two cycles after a mul with E=2
        drive(1, 0, 1, 9, 3, 2, 0, 0, 0, 0);
        tick();
        nop();
        tick();
        drive(1, 0, 1, 3, 0, 0, 1, 1, 0, 0);
        expect4("wb.t2", 1, 0, 0, 1);
        tick();
        expect4("wb.t3", 0, 0, 0, 0);
        tick();
        drain(5);

        // WAW: shorter new latency waits; equal latency reloads the counter
        drive(1, 0, 1, 7, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 7, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expect4($sformatf("waw.short%0d", i), 1, 0, 1, 0);
            tick();
        end
        expect4("waw.short3", 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 7, 3, 0, 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 7, 3, 0, 0, 0, 0, 0);
        expect4("waw.equal", 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 7, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expect4($sformatf("waw.reload%0d", i), 1, 1, 0, 0);
            tick();
        end
        expect4("waw.reload3", 0, 0, 0, 0);
        tick();
        drain(2);

        // Flush together with a RAW stall still reports the stall
        drive(1, 0, 1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        drive(1, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        expect4("flushstall", 1, 1, 0, 0);
        tick();
        drain(2);

        // Flushed write and r0 write leave no trace
        drive(1, 1, 1, 6, 2, 0, 0, 0, 0, 0);
        expect4("flush.w6", 0, 0, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 6, 1, 0, 0);
        expect4("flush.rd6", 0, 0, 0, 0);
        check("flush.idle", idle, 1);
        tick();
        drive(1, 0, 1, 0, 5, 5, 0, 0, 0, 0);
        expect4("r0.w", 0, 0, 0, 0);
        tick();
        drive(1, 0, 1, 3, 0, 4, 0, 1, 0, 1);
        expect4("r0.rd", 0, 0, 0, 0);
        check("r0.idle", idle, 1);
        tick();
        drain(6);

        // Asynchronous reset mid-cycle drops a pending write
        drive(1, 0, 1, 5, 2, 0, 0, 0, 0, 0);
        tick();
        nop();
        #1;
        rst = 1'b1;
        #1;
        check("arst.idle", idle, 1);
        drive(1, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        expect4("arst.during", 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        expect4("arst.after", 0, 0, 0, 0);
        check("arst.idle2", idle, 1);
        tick();
        drain(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
